// File: rtl/cim_layer_seq_pkg.sv
// Shared types and constants for the CIM layer sequencer.
//   seq_state_t : sequencer FSM states
//   ERR_*       : values reported on o_err_code
//   is_busy_state : states in which the layer reports itself busy
package cim_layer_seq_pkg;

    typedef enum logic [2:0] {
        FILL     = 3'd0,
        LOAD     = 3'd1,
        EXEC     = 3'd2,
        WAIT_NXT = 3'd3,
        FUNC     = 3'd4,
        ERR      = 3'd5
    } seq_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_OVERRUN = 2'd2;

    function automatic logic is_busy_state(seq_state_t s);
        return (s != FILL) && (s != ERR);
    endfunction

endpackage

// File: rtl/cim_layer_seq_if.sv
// Handshake bundle between one CIM layer sequencer and its neighbours.
//   i_ibuf_we / o_prev_busy           : previous layer writes into the input buffer
//   o_ctrl_start / i_ctrl_busy        : input-load controller handshake
//   o_cim_exec / i_cim_busy           : crossbar MVM handshake
//   i_next_busy                       : next-layer backpressure
//   o_func_start / i_func_busy        : output function handshake
//   i_clr_err, o_busy, o_err, o_err_code, o_inf_cnt : control and status
// Modports: slave = the sequencer, master = the surrounding environment.
interface cim_layer_seq_if #(
    parameter int unsigned CNT_W = 16
) ();

    logic             i_ibuf_we;
    logic             i_clr_err;
    logic             o_prev_busy;
    logic             o_ctrl_start;
    logic             i_ctrl_busy;
    logic             o_cim_exec;
    logic             i_cim_busy;
    logic             i_next_busy;
    logic             o_func_start;
    logic             i_func_busy;
    logic             o_busy;
    logic             o_err;
    logic [1:0]       o_err_code;
    logic [CNT_W-1:0] o_inf_cnt;

    modport slave (
        input  i_ibuf_we, i_clr_err, i_ctrl_busy, i_cim_busy, i_next_busy, i_func_busy,
        output o_prev_busy, o_ctrl_start, o_cim_exec, o_func_start, o_busy, o_err,
        output o_err_code, o_inf_cnt
    );

    modport master (
        output i_ibuf_we, i_clr_err, i_ctrl_busy, i_cim_busy, i_next_busy, i_func_busy,
        input  o_prev_busy, o_ctrl_start, o_cim_exec, o_func_start, o_busy, o_err,
        input  o_err_code, o_inf_cnt
    );

endinterface

// File: rtl/cim_layer_seq_busy_wait.sv
// Tracks one start/busy handshake and its watchdog.
//   clk, rst : clock, asynchronous active-high reset
//   en       : the owning FSM state is active; all tracking clears when low
//   start    : start pulse issued on state entry
//   busy     : busy line of the unit being waited on
//   done     : busy has been seen high and is now low again
//   timeout  : the state has lasted TIMEOUT cycles without finishing
module cim_layer_seq_busy_wait #(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic start,
    input  logic busy,
    output logic done,
    output logic timeout
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic          seen_q, seen_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        // Busy high in the pulse cycle itself already counts as the rise.
        seen_d = en & ((seen_q & ~start) | busy);
        cnt_d  = en ? cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            seen_q <= seen_d;
            cnt_q  <= cnt_d;
        end
    end

    assign done    = en & seen_q & ~busy;
    assign timeout = en & (cnt_q == LAST);

endmodule

// File: rtl/cim_layer_seq.sv
// Per-layer scheduler for one CIM layer: counts input-buffer writes, then runs
// the ctrl load, crossbar MVM and output function in turn, throttling the
// previous layer and trapping stalled handshakes or buffer overruns.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : cim_layer_seq_if slave modport carrying all handshakes and status
// All outputs are registered and derived from the next state.
module cim_layer_seq
    import cim_layer_seq_pkg::*;
#(
    parameter int unsigned input_size = 201,
    parameter int unsigned TIMEOUT    = 4096,
    parameter int unsigned CNT_W      = 16
) (
    input  logic           clk,
    input  logic           rst,
    cim_layer_seq_if.slave bus
);

    localparam int unsigned FW = (input_size > 1) ? $clog2(input_size) : 1;
    localparam logic [FW-1:0] FILL_LAST = FW'(input_size - 1);

    seq_state_t       state_q, state_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [CNT_W-1:0] inf_q, inf_d;
    logic [1:0]       code_q, code_d;
    logic             prev_busy_q, busy_q, err_q;
    logic             ctrl_start_q, cim_exec_q, func_start_q;

    logic ctrl_done, ctrl_to;
    logic cim_done, cim_to;
    logic func_done, func_to;
    logic any_timeout, overrun;

    cim_layer_seq_busy_wait #(.TIMEOUT(TIMEOUT)) u_wait_ctrl (
        .clk     (clk),
        .rst     (rst),
        .en      (state_q == LOAD),
        .start   (ctrl_start_q),
        .busy    (bus.i_ctrl_busy),
        .done    (ctrl_done),
        .timeout (ctrl_to)
    );

    cim_layer_seq_busy_wait #(.TIMEOUT(TIMEOUT)) u_wait_cim (
        .clk     (clk),
        .rst     (rst),
        .en      (state_q == EXEC),
        .start   (cim_exec_q),
        .busy    (bus.i_cim_busy),
        .done    (cim_done),
        .timeout (cim_to)
    );

    cim_layer_seq_busy_wait #(.TIMEOUT(TIMEOUT)) u_wait_func (
        .clk     (clk),
        .rst     (rst),
        .en      (state_q == FUNC),
        .start   (func_start_q),
        .busy    (bus.i_func_busy),
        .done    (func_done),
        .timeout (func_to)
    );

    assign any_timeout = ctrl_to | cim_to | func_to;
    assign overrun     = bus.i_ibuf_we & prev_busy_q;

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        inf_d   = inf_q;
        code_d  = code_q;

        unique case (state_q)
            FILL: begin
                if (bus.i_ibuf_we) begin
                    if (fill_q == FILL_LAST) begin
                        fill_d  = '0;
                        state_d = LOAD;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
            end
            LOAD:     if (ctrl_done) state_d = EXEC;
            EXEC:     if (cim_done) state_d = WAIT_NXT;
            WAIT_NXT: if (!bus.i_next_busy) state_d = FUNC;
            FUNC: begin
                if (func_done) begin
                    inf_d   = inf_q + 1'b1;
                    state_d = FILL;
                end
            end
            ERR: begin
                if (bus.i_clr_err) begin
                    state_d = FILL;
                    fill_d  = '0;
                    code_d  = ERR_NONE;
                end
            end
            default: state_d = FILL;
        endcase

        // Faults override normal progress; a timeout outranks an overrun.
        if (state_q != ERR) begin
            if (any_timeout) begin
                state_d = ERR;
                code_d  = ERR_TIMEOUT;
                inf_d   = inf_q;
            end else if (overrun) begin
                state_d = ERR;
                code_d  = ERR_OVERRUN;
                inf_d   = inf_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FILL;
            fill_q       <= '0;
            inf_q        <= '0;
            code_q       <= ERR_NONE;
            prev_busy_q  <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            ctrl_start_q <= 1'b0;
            cim_exec_q   <= 1'b0;
            func_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            inf_q        <= inf_d;
            code_q       <= code_d;
            prev_busy_q  <= (state_d != FILL);
            busy_q       <= is_busy_state(state_d);
            err_q        <= (state_d == ERR);
            // Start pulses fire only in the first cycle of their state.
            ctrl_start_q <= (state_d == LOAD) && (state_q != LOAD);
            cim_exec_q   <= (state_d == EXEC) && (state_q != EXEC);
            func_start_q <= (state_d == FUNC) && (state_q != FUNC);
        end
    end

    assign bus.o_prev_busy  = prev_busy_q;
    assign bus.o_ctrl_start = ctrl_start_q;
    assign bus.o_cim_exec   = cim_exec_q;
    assign bus.o_func_start = func_start_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_err        = err_q;
    assign bus.o_err_code   = code_q;
    assign bus.o_inf_cnt    = inf_q;

endmodule

// File: tb/tb_cim_layer_seq.sv
// Directed self-checking bench for cim_layer_seq (input_size=201, TIMEOUT=16, CNT_W=2).
module tb_cim_layer_seq;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   n_ctrl = 0;
    int   n_exec = 0;
    int   n_func = 0;

    cim_layer_seq_if #(.CNT_W(2)) bus ();

    cim_layer_seq #(
        .input_size (201),
        .TIMEOUT    (16),
        .CNT_W      (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.o_ctrl_start === 1'b1) n_ctrl++;
        if (bus.o_cim_exec === 1'b1) n_exec++;
        if (bus.o_func_start === 1'b1) n_func++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_words(input int n);
        for (int i = 0; i < n; i++) begin
            bus.i_ibuf_we = 1'b1;
            tick();
        end
        bus.i_ibuf_we = 1'b0;
    endtask

    // Hold one busy line high for n cycles, drop it, and step to the next state.
    task automatic busy_for(input int sel, input int n);
        case (sel)
            0: bus.i_ctrl_busy = 1'b1;
            1: bus.i_cim_busy  = 1'b1;
            default: bus.i_func_busy = 1'b1;
        endcase
        repeat (n) tick();
        bus.i_ctrl_busy = 1'b0;
        bus.i_cim_busy  = 1'b0;
        bus.i_func_busy = 1'b0;
        tick();
    endtask

    task automatic run_inference(input int exp_inf);
        write_words(201);
        chk("inf_ctrl_start", 32'(bus.o_ctrl_start), 32'd1);
        busy_for(0, 3);
        chk("inf_cim_exec", 32'(bus.o_cim_exec), 32'd1);
        busy_for(1, 5);
        tick();
        chk("inf_func_start", 32'(bus.o_func_start), 32'd1);
        busy_for(2, 4);
        chk("inf_cnt", 32'(bus.o_inf_cnt), 32'(exp_inf));
        chk("inf_prev_busy", 32'(bus.o_prev_busy), 32'd0);
    endtask

    logic [1:0] wrap_seq [5];

    initial begin
        wrap_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rst             = 1'b0;
        bus.i_ibuf_we   = 1'b0;
        bus.i_clr_err   = 1'b0;
        bus.i_ctrl_busy = 1'b0;
        bus.i_cim_busy  = 1'b0;
        bus.i_next_busy = 1'b0;
        bus.i_func_busy = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_prev_busy", 32'(bus.o_prev_busy), 32'd0);
        chk("rst_err", 32'(bus.o_err), 32'd0);
        chk("rst_code", 32'(bus.o_err_code), 32'd0);
        chk("rst_inf", 32'(bus.o_inf_cnt), 32'd0);
        chk("rst_ctrl_start", 32'(bus.o_ctrl_start), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // 1. Nominal flow
        write_words(200);
        chk("t1_fill200_prev_busy", 32'(bus.o_prev_busy), 32'd0);
        chk("t1_fill200_no_start", 32'(bus.o_ctrl_start), 32'd0);
        write_words(1);
        chk("t1_ctrl_start", 32'(bus.o_ctrl_start), 32'd1);
        chk("t1_prev_busy", 32'(bus.o_prev_busy), 32'd1);
        chk("t1_busy", 32'(bus.o_busy), 32'd1);
        busy_for(0, 3);
        chk("t1_cim_exec", 32'(bus.o_cim_exec), 32'd1);
        busy_for(1, 5);
        chk("t1_wait_nxt_busy", 32'(bus.o_busy), 32'd1);
        chk("t1_wait_nxt_no_func", 32'(bus.o_func_start), 32'd0);
        tick();
        chk("t1_func_start", 32'(bus.o_func_start), 32'd1);
        busy_for(2, 4);
        chk("t1_inf", 32'(bus.o_inf_cnt), 32'd1);
        chk("t1_prev_busy_fill", 32'(bus.o_prev_busy), 32'd0);
        chk("t1_busy_fill", 32'(bus.o_busy), 32'd0);
        chk("t1_n_ctrl", 32'(n_ctrl), 32'd1);
        chk("t1_n_exec", 32'(n_exec), 32'd1);
        chk("t1_n_func", 32'(n_func), 32'd1);

        // 2. Backpressure
        write_words(201);
        busy_for(0, 3);
        bus.i_next_busy = 1'b1;
        busy_for(1, 5);
        repeat (10000) tick();
        chk("t2_no_err", 32'(bus.o_err), 32'd0);
        chk("t2_still_busy", 32'(bus.o_busy), 32'd1);
        chk("t2_n_func_held", 32'(n_func), 32'd1);
        bus.i_next_busy = 1'b0;
        chk("t2_no_func_yet", 32'(bus.o_func_start), 32'd0);
        tick();
        chk("t2_func_start", 32'(bus.o_func_start), 32'd1);
        busy_for(2, 4);
        chk("t2_inf", 32'(bus.o_inf_cnt), 32'd2);

        // 3. Timeout in EXEC
        write_words(201);
        busy_for(0, 3);
        chk("t3_cim_exec", 32'(bus.o_cim_exec), 32'd1);
        repeat (15) tick();
        chk("t3_err_before", 32'(bus.o_err), 32'd0);
        tick();
        chk("t3_err", 32'(bus.o_err), 32'd1);
        chk("t3_code", 32'(bus.o_err_code), 32'd1);
        chk("t3_busy", 32'(bus.o_busy), 32'd0);
        chk("t3_prev_busy", 32'(bus.o_prev_busy), 32'd1);
        repeat (3) tick();
        chk("t3_err_sticky", 32'(bus.o_err), 32'd1);
        bus.i_clr_err = 1'b1;
        tick();
        bus.i_clr_err = 1'b0;
        chk("t3_clr_err", 32'(bus.o_err), 32'd0);
        chk("t3_clr_code", 32'(bus.o_err_code), 32'd0);
        chk("t3_clr_prev_busy", 32'(bus.o_prev_busy), 32'd0);
        chk("t3_inf_kept", 32'(bus.o_inf_cnt), 32'd2);

        // 3b. Timeout and overrun in the same cycle: timeout code wins
        write_words(201);
        busy_for(0, 3);
        repeat (15) tick();
        bus.i_ibuf_we = 1'b1;
        tick();
        bus.i_ibuf_we = 1'b0;
        chk("t3b_code", 32'(bus.o_err_code), 32'd1);
        bus.i_clr_err = 1'b1;
        tick();
        bus.i_clr_err = 1'b0;

        // 4. Overrun: 202nd write right after the 201st
        write_words(201);
        bus.i_ibuf_we = 1'b1;
        tick();
        bus.i_ibuf_we = 1'b0;
        chk("t4_err", 32'(bus.o_err), 32'd1);
        chk("t4_code", 32'(bus.o_err_code), 32'd2);
        repeat (5) tick();
        chk("t4_n_ctrl", 32'(n_ctrl), 32'd5);
        chk("t4_err_sticky", 32'(bus.o_err), 32'd1);
        bus.i_clr_err = 1'b1;
        tick();
        bus.i_clr_err = 1'b0;
        chk("t4_clr_prev_busy", 32'(bus.o_prev_busy), 32'd0);
        run_inference(3);

        // 5. Reset mid-EXEC
        write_words(201);
        busy_for(0, 3);
        chk("t5_cim_exec", 32'(bus.o_cim_exec), 32'd1);
        bus.i_cim_busy = 1'b1;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("t5_busy", 32'(bus.o_busy), 32'd0);
        chk("t5_prev_busy", 32'(bus.o_prev_busy), 32'd0);
        chk("t5_inf", 32'(bus.o_inf_cnt), 32'd0);
        chk("t5_err", 32'(bus.o_err), 32'd0);
        chk("t5_cim_exec_rst", 32'(bus.o_cim_exec), 32'd0);
        bus.i_cim_busy = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // 6. Back-to-back with counter wrap
        for (int k = 0; k < 5; k++) run_inference(int'(wrap_seq[k]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
